// File: rtl/core_ex_pkg.sv
// Shared types and ALU opcode encodings for the EX stage.
package core_ex_pkg;

  localparam int OP_W       = 5;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_RD_W   = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
  localparam logic [OP_W-1:0] ALU_AND = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 5'd4;
  localparam logic [OP_W-1:0] ALU_SLL = 5'd5;
  localparam logic [OP_W-1:0] ALU_SRL = 5'd6;
  localparam logic [OP_W-1:0] ALU_SLT = 5'd7;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [REQ_DATA_W-1:0] in1;
    logic [REQ_DATA_W-1:0] in2;
    logic [REQ_RD_W-1:0]   rd;
    logic                  reg_write;
  } ex_req_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } seq_state_e;

endpackage

// File: rtl/core_ex_out_slot.sv
// EX/MEM output slot: a single valid/ready register whose contents stay put
// until MEM consumes them.
module core_ex_out_slot
  import core_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              load,
  input  logic [DATA_W-1:0] load_result,
  input  logic [RD_W-1:0]   load_rd,
  input  logic              load_reg_write,
  input  logic              em_ready,
  output logic              em_valid,
  output logic [DATA_W-1:0] em_result,
  output logic [RD_W-1:0]   em_rd,
  output logic              em_reg_write
);

  // A refill in the same cycle as a consume keeps the slot full.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      em_valid     <= 1'b0;
      em_result    <= '0;
      em_rd        <= '0;
      em_reg_write <= 1'b0;
    end else if (load) begin
      em_valid     <= 1'b1;
      em_result    <= load_result;
      em_rd        <= load_rd;
      em_reg_write <= load_reg_write;
    end else if (em_ready) begin
      em_valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/core_ex_alu_seq.sv
// EX-stage sequencer between ID/EX and the shared multi-cycle ALU.
// Define CORE_EX_ALU_SEQ_PERF_EN to add stall/hold performance counters.
module core_ex_alu_seq #(
  parameter int OP_W   = 5,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              flush_en,
  input  logic              de_valid,
  output logic              de_ready,
  input  logic [OP_W-1:0]   de_alu_op,
  input  logic [DATA_W-1:0] de_in1,
  input  logic [DATA_W-1:0] de_in2,
  input  logic [RD_W-1:0]   de_rd,
  input  logic              de_reg_write,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_op_valid,
  input  logic              alu_op_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  output logic              alu_op_kill,
  output logic              em_valid,
  input  logic              em_ready,
  output logic [DATA_W-1:0] em_result,
  output logic [RD_W-1:0]   em_rd,
  output logic              em_reg_write,
`ifdef CORE_EX_ALU_SEQ_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_hold_cnt,
`endif
  output logic              busy
);

  import core_ex_pkg::*;

  seq_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] in1_q, in2_q, res_q;
  logic [RD_W-1:0]   rd_q;
  logic              wr_q;

  logic              slot_free;
  logic              op_load, op_clear, res_load, em_load;
  logic [DATA_W-1:0] em_load_result;

  assign slot_free = !em_valid || em_ready;
  assign alu_op    = op_q;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Flush outranks everything, including an ALU completion in the same cycle.
  always_comb begin
    state_d        = state_q;
    de_ready       = 1'b0;
    alu_op_valid   = 1'b0;
    alu_op_kill    = 1'b0;
    op_load        = 1'b0;
    op_clear       = 1'b0;
    res_load       = 1'b0;
    em_load        = 1'b0;
    em_load_result = alu_out;
    case (state_q)
      IDLE: begin
        if (flush_en) begin
          op_clear = 1'b1;
        end else begin
          de_ready = 1'b1;
          if (de_valid) begin
            op_load = 1'b1;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        alu_op_valid = 1'b1;
        if (flush_en) begin
          alu_op_kill = 1'b1;
          op_clear    = 1'b1;
          state_d     = IDLE;
        end else if (alu_op_ready && slot_free) begin
          em_load  = 1'b1;
          de_ready = 1'b1;
          if (de_valid) op_load = 1'b1;
          else          state_d = IDLE;
        end else if (alu_op_ready) begin
          res_load = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (flush_en) begin
          op_clear = 1'b1;
          state_d  = IDLE;
        end else if (em_ready) begin
          em_load        = 1'b1;
          em_load_result = res_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      op_q  <= '0;
      in1_q <= '0;
      in2_q <= '0;
      rd_q  <= '0;
      wr_q  <= 1'b0;
      res_q <= '0;
    end else begin
      if (op_clear) begin
        op_q  <= '0;
        in1_q <= '0;
        in2_q <= '0;
        rd_q  <= '0;
        wr_q  <= 1'b0;
      end else if (op_load) begin
        op_q  <= de_alu_op;
        in1_q <= de_in1;
        in2_q <= de_in2;
        rd_q  <= de_rd;
        wr_q  <= de_reg_write;
      end
      if (op_clear)      res_q <= '0;
      else if (res_load) res_q <= alu_out;
    end
  end

  core_ex_out_slot #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_out_slot (
    .clk            (clk),
    .rest           (rest),
    .load           (em_load),
    .load_result    (em_load_result),
    .load_rd        (rd_q),
    .load_reg_write (wr_q),
    .em_ready       (em_ready),
    .em_valid       (em_valid),
    .em_result      (em_result),
    .em_rd          (em_rd),
    .em_reg_write   (em_reg_write)
  );

`ifdef CORE_EX_ALU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      perf_stall_cnt <= '0;
      perf_hold_cnt  <= '0;
    end else begin
      if (state_q == EXEC && !alu_op_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (state_q == HOLD)                  perf_hold_cnt  <= perf_hold_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_ex_alu_seq.sv
// Directed testbench for core_ex_alu_seq; the bench plays both the ALU and MEM.
module tb_core_ex_alu_seq;
  import core_ex_pkg::*;

  localparam int N_VEC = 8;

  typedef struct packed {
    ex_req_t     req;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rest;
  logic        flush_en, de_valid, de_ready, de_reg_write;
  logic [4:0]  de_alu_op, de_rd, alu_op, em_rd;
  logic [31:0] de_in1, de_in2, alu_in1, alu_in2, alu_out, em_result;
  logic        alu_op_valid, alu_op_ready, alu_op_kill;
  logic        em_valid, em_ready, em_reg_write, busy;
  logic        alu_auto, manual_ready;
  logic [31:0] manual_out;
`ifdef CORE_EX_ALU_SEQ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_hold_cnt, stall_base, hold_base;
`endif

  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t vecs [N_VEC];

  core_ex_alu_seq dut (
    .clk            (clk),
    .rest           (rest),
    .flush_en       (flush_en),
    .de_valid       (de_valid),
    .de_ready       (de_ready),
    .de_alu_op      (de_alu_op),
    .de_in1         (de_in1),
    .de_in2         (de_in2),
    .de_rd          (de_rd),
    .de_reg_write   (de_reg_write),
    .alu_op         (alu_op),
    .alu_op_valid   (alu_op_valid),
    .alu_op_ready   (alu_op_ready),
    .alu_in1        (alu_in1),
    .alu_in2        (alu_in2),
    .alu_out        (alu_out),
    .alu_op_kill    (alu_op_kill),
    .em_valid       (em_valid),
    .em_ready       (em_ready),
    .em_result      (em_result),
    .em_rd          (em_rd),
    .em_reg_write   (em_reg_write),
`ifdef CORE_EX_ALU_SEQ_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_hold_cnt  (perf_hold_cnt),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Single-cycle ALU stand-in when alu_auto is set, otherwise scripted by the sequences.
  always_comb begin
    alu_op_ready = manual_ready;
    alu_out      = manual_out;
    if (alu_auto) begin
      alu_op_ready = 1'b1;
      case (alu_op)
        ALU_ADD: alu_out = alu_in1 + alu_in2;
        ALU_SUB: alu_out = alu_in1 - alu_in2;
        ALU_AND: alu_out = alu_in1 & alu_in2;
        ALU_OR:  alu_out = alu_in1 | alu_in2;
        ALU_XOR: alu_out = alu_in1 ^ alu_in2;
        ALU_SLL: alu_out = alu_in1 << alu_in2[4:0];
        default: alu_out = '0;
      endcase
    end
  end

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic wr, input logic [31:0] exp);
    vec_t v;
    v.req.op = op; v.req.in1 = a; v.req.in2 = b; v.req.rd = rd; v.req.reg_write = wr;
    v.exp = exp;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input ex_req_t req);
    de_valid     = valid;
    de_alu_op    = req.op;
    de_in1       = req.in1;
    de_in2       = req.in2;
    de_rd        = req.rd;
    de_reg_write = req.reg_write;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(ALU_ADD, 32'd3,         32'd4,         5'd1,  1'b1, 32'd7);
    vecs[1] = mk(ALU_ADD, 32'd5,         32'd6,         5'd2,  1'b1, 32'd11);
    vecs[2] = mk(ALU_SUB, 32'd10,        32'd3,         5'd3,  1'b1, 32'd7);
    vecs[3] = mk(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd4,  1'b1, 32'h0000_F000);
    vecs[4] = mk(ALU_OR,  32'h0000_000F, 32'h0000_00F0, 5'd5,  1'b0, 32'h0000_00FF);
    vecs[5] = mk(ALU_XOR, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6,  1'b1, 32'hFFFF_FFFE);
    vecs[6] = mk(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 1'b1, 32'h0000_0000);
    vecs[7] = mk(ALU_SLL, 32'h0000_0001, 32'd4,         5'd7,  1'b0, 32'h0000_0010);

    rest = 1'b0; flush_en = 1'b0; em_ready = 1'b1;
    alu_auto = 1'b1; manual_ready = 1'b0; manual_out = '0;
    apply_stimulus(1'b0, '0);

    #3;
    check_output("reset_de_ready", de_ready, 1);
    check_output("reset_em_valid", em_valid, 0);
    check_output("reset_em_result", em_result, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_alu_op_valid", alu_op_valid, 0);
    check_output("reset_alu_op_kill", alu_op_kill, 0);
`ifdef CORE_EX_ALU_SEQ_PERF_EN
    check_output("reset_perf_stall", perf_stall_cnt, 0);
    check_output("reset_perf_hold", perf_hold_cnt, 0);
`endif
    @(negedge clk);
    rest = 1'b1;

    // Back-to-back single-cycle ops: result of vector i appears two cycles after it is offered.
    for (int i = 0; i < N_VEC + 2; i++) begin
      @(negedge clk);
      if (i < N_VEC) apply_stimulus(1'b1, vecs[i].req);
      else           de_valid = 1'b0;
      #1;
      if (i < N_VEC) check_output("stream_de_ready", de_ready, 1);
      if (i >= 2) begin
        check_output("stream_em_valid", em_valid, 1);
        check_output("stream_em_result", em_result, vecs[i-2].exp);
        check_output("stream_em_rd", em_rd, vecs[i-2].req.rd);
        check_output("stream_em_reg_write", em_reg_write, vecs[i-2].req.reg_write);
      end
    end
    @(negedge clk); #1;
    check_output("stream_drain_em_valid", em_valid, 0);
    check_output("stream_drain_busy", busy, 0);

    // Multi-cycle op: ALU completes in the 4th EXEC cycle.
    alu_auto = 1'b0;
    @(negedge clk);
    apply_stimulus(1'b1, mk(ALU_ADD, 32'h10, 32'h10, 5'd7, 1'b1, 32'h0).req);
`ifdef CORE_EX_ALU_SEQ_PERF_EN
    stall_base = perf_stall_cnt;
`endif
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      de_valid     = 1'b0;
      manual_ready = (e == 4);
      manual_out   = (e == 4) ? 32'h20 : 32'hBAD;
      #1;
      check_output("mc_alu_op_valid", alu_op_valid, 1);
      check_output("mc_alu_in1_stable", alu_in1, 32'h10);
      check_output("mc_alu_in2_stable", alu_in2, 32'h10);
      check_output("mc_de_ready", de_ready, (e == 4) ? 1 : 0);
    end
    @(negedge clk);
    manual_ready = 1'b0;
    #1;
    check_output("mc_em_valid", em_valid, 1);
    check_output("mc_em_result", em_result, 32'h20);
    check_output("mc_em_rd", em_rd, 7);
    check_output("mc_busy", busy, 0);
`ifdef CORE_EX_ALU_SEQ_PERF_EN
    check_output("mc_perf_stall_delta", perf_stall_cnt - stall_base, 3);
`endif
    @(negedge clk); #1;
    check_output("mc_em_drain", em_valid, 0);

    // MEM backpressure: X fills the slot, Y completes while it is still full and parks in HOLD.
    @(negedge clk);
    em_ready = 1'b0;
    apply_stimulus(1'b1, mk(ALU_ADD, 32'd1, 32'd1, 5'd3, 1'b1, 32'h0).req);
    @(negedge clk);
    apply_stimulus(1'b1, mk(ALU_ADD, 32'd0, 32'd0, 5'd9, 1'b1, 32'h0).req);
    manual_ready = 1'b1; manual_out = 32'd2;
    #1;
    check_output("bp_de_ready_x_done", de_ready, 1);
    @(negedge clk);
    de_valid = 1'b0; manual_out = 32'hDEAD_BEEF;
    #1;
    check_output("bp_em_valid_x", em_valid, 1);
    check_output("bp_em_result_x", em_result, 32'd2);
`ifdef CORE_EX_ALU_SEQ_PERF_EN
    hold_base = perf_hold_cnt;
`endif
    @(negedge clk);
    manual_ready = 1'b0;
    #1;
    check_output("bp_hold_busy", busy, 1);
    check_output("bp_hold_de_ready", de_ready, 0);
    check_output("bp_hold_alu_op_valid", alu_op_valid, 0);
    check_output("bp_hold_em_stable", em_result, 32'd2);
    @(negedge clk); #1;
    check_output("bp_hold2_em_stable", em_result, 32'd2);
    check_output("bp_hold2_de_ready", de_ready, 0);
    @(negedge clk);
    em_ready = 1'b1;
    #1;
    check_output("bp_hold3_de_ready", de_ready, 0);
    @(negedge clk); #1;
    check_output("bp_em_valid_y", em_valid, 1);
    check_output("bp_em_result_y", em_result, 32'hDEAD_BEEF);
    check_output("bp_em_rd_y", em_rd, 9);
    check_output("bp_idle_busy", busy, 0);
    check_output("bp_idle_de_ready", de_ready, 1);
`ifdef CORE_EX_ALU_SEQ_PERF_EN
    check_output("bp_perf_hold_delta", perf_hold_cnt - hold_base, 3);
`endif
    @(negedge clk); #1;
    check_output("bp_em_drain", em_valid, 0);

    // Flush in the 2nd EXEC cycle of B while the ALU reports done; slot holds A.
    @(negedge clk);
    em_ready = 1'b0;
    apply_stimulus(1'b1, mk(ALU_ADD, 32'd0, 32'd0, 5'd1, 1'b1, 32'h0).req);
    @(negedge clk);
    apply_stimulus(1'b1, mk(ALU_SUB, 32'd0, 32'd0, 5'd2, 1'b1, 32'h0).req);
    manual_ready = 1'b1; manual_out = 32'h55;
    @(negedge clk);
    de_valid = 1'b0; manual_ready = 1'b0;
    #1;
    check_output("fl_em_result_a", em_result, 32'h55);
    @(negedge clk);
    flush_en = 1'b1; manual_ready = 1'b1; manual_out = 32'h99;
    #1;
    check_output("fl_alu_op_kill", alu_op_kill, 1);
    check_output("fl_de_ready", de_ready, 0);
    @(negedge clk);
    flush_en = 1'b0; manual_ready = 1'b0;
    #1;
    check_output("fl_kill_one_cycle", alu_op_kill, 0);
    check_output("fl_busy", busy, 0);
    check_output("fl_alu_op_valid", alu_op_valid, 0);
    check_output("fl_em_valid", em_valid, 1);
    check_output("fl_em_result", em_result, 32'h55);
    check_output("fl_em_rd", em_rd, 1);
    check_output("fl_de_ready_after", de_ready, 1);

    // Flush while in HOLD: the parked result must be dropped.
    @(negedge clk);
    apply_stimulus(1'b1, mk(ALU_OR, 32'd0, 32'd0, 5'd4, 1'b1, 32'h0).req);
    @(negedge clk);
    de_valid = 1'b0; manual_ready = 1'b1; manual_out = 32'h77;
    @(negedge clk);
    manual_ready = 1'b0; flush_en = 1'b1;
    #1;
    check_output("flh_de_ready", de_ready, 0);
    check_output("flh_no_kill", alu_op_kill, 0);
    @(negedge clk);
    flush_en = 1'b0;
    #1;
    check_output("flh_busy", busy, 0);
    check_output("flh_em_result", em_result, 32'h55);
    @(negedge clk);
    em_ready = 1'b1;
    @(negedge clk); #1;
    check_output("flh_no_refill", em_valid, 0);

    // Asynchronous reset while parked in HOLD.
    @(negedge clk);
    em_ready = 1'b0;
    apply_stimulus(1'b1, mk(ALU_ADD, 32'd0, 32'd0, 5'd5, 1'b1, 32'h0).req);
    @(negedge clk);
    apply_stimulus(1'b1, mk(ALU_ADD, 32'd0, 32'd0, 5'd6, 1'b1, 32'h0).req);
    manual_ready = 1'b1; manual_out = 32'h11;
    @(negedge clk);
    de_valid = 1'b0; manual_out = 32'h22;
    @(negedge clk);
    manual_ready = 1'b0;
    #1;
    check_output("rst_pre_busy", busy, 1);
    rest = 1'b0;
    #1;
    check_output("rst_em_valid", em_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_em_result", em_result, 0);
    rest = 1'b1;
    #1;
    check_output("rst_rel_de_ready", de_ready, 1);
    check_output("rst_rel_busy", busy, 0);
    check_output("rst_rel_em_valid", em_valid, 0);
    check_output("rst_rel_kill", alu_op_kill, 0);
`ifdef CORE_EX_ALU_SEQ_PERF_EN
    check_output("rst_perf_stall", perf_stall_cnt, 0);
    check_output("rst_perf_hold", perf_hold_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
